// File: rtl/stream_pkt_sink_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_pkt_sink_pkg
// Shared status bit positions, descriptor type, FSM state type and keep
// helpers for the packet sink.
// Revision: 1.0
// ---------------------------------------------------------------------------
package stream_pkt_sink_pkg;

  localparam int STAT_ERR   = 0;
  localparam int STAT_NOEOP = 1;
  localparam int STAT_KEEP  = 2;
  localparam int STAT_OVF   = 3;

  // Widest keep vector the helpers handle (512-bit data bus).
  localparam int KEEP_MAX_W = 64;
  localparam int DESC_LEN_W = 16;

  typedef struct packed {
    logic [DESC_LEN_W-1:0] len;
    logic [3:0]            status;
  } desc_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  // Number of enabled bytes in a (zero-extended) keep vector.
  function automatic logic [7:0] popcount_keep(input logic [KEEP_MAX_W-1:0] keep);
    logic [7:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      cnt = cnt + {7'd0, keep[i]};
    end
    return cnt;
  endfunction

  // True when keep is nonzero and its ones form a run starting at bit 0.
  function automatic logic keep_contig(input logic [KEEP_MAX_W-1:0] keep);
    return (keep != '0) && ((keep & (keep + 1'b1)) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_pkt_sink_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_pkt_sink_if
// sop/eop/keep byte-stream bus with master and slave views.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface stream_pkt_sink_if #(
  parameter int DATA_W = 64
) ();

  logic                valid;
  logic [DATA_W-1:0]   data;
  logic [DATA_W/8-1:0] keep;
  logic                sop;
  logic                eop;
  logic                err;
  logic                ready;

  modport master (
    output valid, data, keep, sop, eop, err,
    input  ready
  );

  modport slave (
    input  valid, data, keep, sop, eop, err,
    output ready
  );

endinterface
`default_nettype wire

// File: rtl/stream_pkt_sink_desc_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_pkt_sink_desc_fifo
// Synchronous first-word-fall-through FIFO for packet descriptors.
// Registered write; head entry visible while not empty, zero when empty.
// Revision: 1.0
// ---------------------------------------------------------------------------
module stream_pkt_sink_desc_fifo
  import stream_pkt_sink_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = desc_t
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  push,
  input  T     push_data,
  input  wire  pop,
  output T     pop_data,
  output logic full,
  output logic empty
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = empty ? T'('0) : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only observed when the slot is occupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/stream_pkt_sink.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stream_pkt_sink
// Slave end of the sop/eop/keep byte stream. Checks framing and keep,
// measures packet length and status, queues one descriptor per packet
// and keeps good/bad/drop statistics.
// Revision: 1.0
// ---------------------------------------------------------------------------
module stream_pkt_sink
  import stream_pkt_sink_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int LEN_W      = 16,
  parameter int DESC_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  wire                clk_i,
  input  wire                rst_n_i,
  stream_pkt_sink_if.slave   s_axis,
  output logic               pkt_valid_o,
  output logic [LEN_W-1:0]   pkt_len_o,
  output logic [3:0]         pkt_status_o,
  input  wire                pkt_ready_i,
  output logic [CNT_W-1:0]   pkt_cnt_o,
  output logic [CNT_W-1:0]   bad_cnt_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  localparam int DATA_BE_W = DATA_W / 8;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [3:0]       status;
  } pkt_desc_t;

  state_t           state;
  logic [LEN_W-1:0] len_acc;
  logic [3:0]       stat_acc;
  logic             ready_en;

  logic             fifo_full;
  logic             fifo_empty;
  pkt_desc_t        head;

  logic             flush_cond;
  logic             flush_go;
  logic             accept;
  logic [7:0]       beat_bytes;
  logic             keep_bad;
  logic [LEN_W-1:0] base_len;
  logic [3:0]       base_stat;
  logic [LEN_W:0]   len_sum;
  logic [LEN_W-1:0] new_len;
  logic [3:0]       new_stat;
  logic             push_eop;
  logic             push;
  pkt_desc_t        push_desc;
  logic             drop;

  // A sop arriving while a packet is open closes that packet instead of
  // being consumed; the flush push only happens once there is space.
  assign flush_cond   = (state == ST_IN_PKT) && s_axis.valid && s_axis.sop;
  assign flush_go     = flush_cond && ready_en && !fifo_full;
  assign s_axis.ready = ready_en && !fifo_full && !flush_cond;
  assign accept       = s_axis.valid && s_axis.ready;

  // Per-beat length/status update and push/drop decisions.
  always_comb begin
    beat_bytes = popcount_keep(KEEP_MAX_W'(s_axis.keep));
    keep_bad   = s_axis.eop ? !keep_contig(KEEP_MAX_W'(s_axis.keep))
                            : (s_axis.keep != '1);
    base_len   = (state == ST_IDLE) ? '0 : len_acc;
    base_stat  = (state == ST_IDLE) ? '0 : stat_acc;
    len_sum    = {1'b0, base_len} + (LEN_W+1)'(beat_bytes);
    new_len    = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    new_stat   = base_stat;
    new_stat[STAT_ERR]  = base_stat[STAT_ERR]  | s_axis.err;
    new_stat[STAT_KEEP] = base_stat[STAT_KEEP] | keep_bad;
    new_stat[STAT_OVF]  = base_stat[STAT_OVF]  | len_sum[LEN_W];

    push_eop = accept && s_axis.eop && ((state == ST_IN_PKT) || s_axis.sop);
    drop     = accept && (state == ST_IDLE) && !s_axis.sop;
    push     = push_eop || flush_go;

    push_desc = '{len: new_len, status: new_stat};
    if (flush_go) begin
      push_desc        = '{len: len_acc, status: stat_acc};
      push_desc.status[STAT_NOEOP] = 1'b1;
    end
  end

  // Packet FSM, accumulators, ready enable and saturating statistics.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      len_acc    <= '0;
      stat_acc   <= '0;
      ready_en   <= 1'b0;
      pkt_cnt_o  <= '0;
      bad_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept && s_axis.sop && !s_axis.eop) begin
            len_acc  <= new_len;
            stat_acc <= new_stat;
            state    <= ST_IN_PKT;
          end
        end
        ST_IN_PKT: begin
          if (flush_go) begin
            state <= ST_IDLE;
          end else if (accept) begin
            len_acc  <= new_len;
            stat_acc <= new_stat;
            if (s_axis.eop) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (push && (push_desc.status == '0) && (pkt_cnt_o != '1))
        pkt_cnt_o <= pkt_cnt_o + 1'b1;
      if (push && (push_desc.status != '0) && (bad_cnt_o != '1))
        bad_cnt_o <= bad_cnt_o + 1'b1;
      if (drop && (drop_cnt_o != '1))
        drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  stream_pkt_sink_desc_fifo #(
    .DEPTH (DESC_DEPTH),
    .T     (pkt_desc_t)
  ) u_desc_fifo (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .push      (push),
    .push_data (push_desc),
    .pop       (pkt_valid_o && pkt_ready_i),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign pkt_valid_o  = !fifo_empty;
  assign pkt_len_o    = head.len;
  assign pkt_status_o = head.status;

endmodule
`default_nettype wire

// File: tb/tb_stream_pkt_sink.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stream_pkt_sink
// Directed self-checking bench for stream_pkt_sink (DATA_W=64, DEPTH=4).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_stream_pkt_sink;

  logic        clk;
  logic        rst_n;
  logic        pkt_valid;
  logic [15:0] pkt_len;
  logic [3:0]  pkt_status;
  logic        pkt_ready;
  logic [15:0] pkt_cnt;
  logic [15:0] bad_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  stream_pkt_sink_if #(.DATA_W(64)) s_axis ();

  stream_pkt_sink #(
    .DATA_W(64), .LEN_W(16), .DESC_DEPTH(4), .CNT_W(16)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .s_axis       (s_axis),
    .pkt_valid_o  (pkt_valid),
    .pkt_len_o    (pkt_len),
    .pkt_status_o (pkt_status),
    .pkt_ready_i  (pkt_ready),
    .pkt_cnt_o    (pkt_cnt),
    .bad_cnt_o    (bad_cnt),
    .drop_cnt_o   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one beat starting just after a rising edge; returns #1 after the
  // edge that accepts it, with the bus idle again.
  task automatic beat(input logic [7:0] keep, input logic sop, input logic eop,
                      input logic err);
    int waited;
    s_axis.valid = 1'b1;
    s_axis.keep  = keep;
    s_axis.sop   = sop;
    s_axis.eop   = eop;
    s_axis.err   = err;
    s_axis.data  = {$urandom, $urandom};
    waited = 0;
    @(negedge clk);
    while (!s_axis.ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      errors++;
      $display("FAIL beat_timeout: ready stayed %0b, required 1", s_axis.ready);
    end
    @(posedge clk); #1;
    s_axis.valid = 1'b0;
    s_axis.sop   = 1'b0;
    s_axis.eop   = 1'b0;
    s_axis.err   = 1'b0;
  endtask

  // Check the head descriptor and pop it.
  task automatic pop_check(input logic [15:0] exp_len, input logic [3:0] exp_stat,
                           input string name);
    checks++;
    if (pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: got %0b required 1", name, pkt_valid);
    end
    checks++;
    if (pkt_len !== exp_len) begin
      errors++;
      $display("FAIL %s_len: got %0d required %0d", name, pkt_len, exp_len);
    end
    checks++;
    if (pkt_status !== exp_stat) begin
      errors++;
      $display("FAIL %s_status: got %b required %b", name, pkt_status, exp_stat);
    end
    pkt_ready = 1'b1;
    @(posedge clk); #1;
    pkt_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_axis.ready, pkt_valid, pkt_len, pkt_status} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%0b valid=%0b len=%0d status=%b required all 0",
               s_axis.ready, pkt_valid, pkt_len, pkt_status);
    end
    checks++;
    if ({pkt_cnt, bad_cnt, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_counters: pkt=%0d bad=%0d drop=%0d required 0",
               pkt_cnt, bad_cnt, drop_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_axis.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready: got %0b required 0", s_axis.ready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_axis.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b required 1", s_axis.ready);
    end
  endtask

  task automatic test_20byte;
    beat(8'hFF, 1'b1, 1'b0, 1'b0);
    beat(8'hFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL p20_early_valid: got %0b required 0", pkt_valid);
    end
    beat(8'h0F, 1'b0, 1'b1, 1'b0);
    checks++;
    if (pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL p20_pkt_cnt: got %0d required 1", pkt_cnt);
    end
    pop_check(16'd20, 4'b0000, "p20");
    checks++;
    if (pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL p20_empty_after_pop: got %0b required 0", pkt_valid);
    end
  endtask

  task automatic test_err_single;
    beat(8'h01, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bad_cnt !== 16'd1) begin
      errors++;
      $display("FAIL err_bad_cnt: got %0d required 1", bad_cnt);
    end
    pop_check(16'd1, 4'b0001, "err");
  endtask

  task automatic test_drop;
    beat(8'hFF, 1'b0, 1'b0, 1'b0);
    checks++;
    if (drop_cnt !== 16'd1) begin
      errors++;
      $display("FAIL drop_cnt: got %0d required 1", drop_cnt);
    end
    checks++;
    if (pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_no_desc: got %0b required 0", pkt_valid);
    end
    beat(8'hFF, 1'b1, 1'b1, 1'b0);
    pop_check(16'd8, 4'b0000, "drop_pkt");
  endtask

  task automatic test_flush;
    beat(8'hFF, 1'b1, 1'b0, 1'b0);
    s_axis.valid = 1'b1;
    s_axis.keep  = 8'h03;
    s_axis.sop   = 1'b1;
    s_axis.eop   = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis.ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_low: got %0b required 0", s_axis.ready);
    end
    @(posedge clk); #1;
    checks++;
    if (s_axis.ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready_back: got %0b required 1", s_axis.ready);
    end
    @(posedge clk); #1;
    s_axis.valid = 1'b0;
    s_axis.sop   = 1'b0;
    s_axis.eop   = 1'b0;
    pop_check(16'd8, 4'b0010, "flush_open");
    pop_check(16'd2, 4'b0000, "flush_next");
    checks++;
    if ({pkt_cnt, bad_cnt} !== {16'd3, 16'd2}) begin
      errors++;
      $display("FAIL flush_counters: pkt=%0d bad=%0d required pkt=3 bad=2",
               pkt_cnt, bad_cnt);
    end
  endtask

  task automatic test_full;
    logic [7:0] keeps [4];
    keeps = '{8'h01, 8'h03, 8'h07, 8'h0F};
    pkt_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(keeps[i], 1'b1, 1'b1, 1'b0);
    s_axis.valid = 1'b1;
    s_axis.keep  = 8'hFF;
    s_axis.sop   = 1'b1;
    s_axis.eop   = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis.ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_low: got %0b required 0", s_axis.ready);
    end
    @(posedge clk); #1;
    pkt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis.ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_pop_cycle: got %0b required 0", s_axis.ready);
    end
    @(posedge clk); #1;
    pkt_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axis.ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_after_pop: got %0b required 1", s_axis.ready);
    end
    @(posedge clk); #1;
    s_axis.valid = 1'b0;
    s_axis.sop   = 1'b0;
    s_axis.eop   = 1'b0;
    pop_check(16'd2, 4'b0000, "full_q1");
    pop_check(16'd3, 4'b0000, "full_q2");
    pop_check(16'd4, 4'b0000, "full_q3");
    pop_check(16'd8, 4'b0000, "full_q4");
    checks++;
    if (pkt_cnt !== 16'd8) begin
      errors++;
      $display("FAIL full_pkt_cnt: got %0d required 8", pkt_cnt);
    end
  endtask

  task automatic test_keep_err;
    beat(8'hFF, 1'b1, 1'b0, 1'b0);
    beat(8'h0F, 1'b0, 1'b0, 1'b0);
    beat(8'hFF, 1'b0, 1'b1, 1'b0);
    pop_check(16'd20, 4'b0100, "keep_mid");
    beat(8'h05, 1'b1, 1'b1, 1'b0);
    pop_check(16'd2, 4'b0100, "keep_gap");
    checks++;
    if (bad_cnt !== 16'd4) begin
      errors++;
      $display("FAIL keep_bad_cnt: got %0d required 4", bad_cnt);
    end
  endtask

  task automatic test_overflow;
    beat(8'hFF, 1'b1, 1'b0, 1'b0);
    s_axis.valid = 1'b1;
    s_axis.keep  = 8'hFF;
    repeat (8191) @(posedge clk);
    #1;
    s_axis.valid = 1'b0;
    beat(8'hFF, 1'b0, 1'b1, 1'b0);
    pop_check(16'hFFFF, 4'b1000, "ovf");
  endtask

  task automatic test_reset_mid;
    beat(8'h01, 1'b1, 1'b1, 1'b0);
    beat(8'hFF, 1'b1, 1'b0, 1'b0);
    s_axis.valid = 1'b1;
    s_axis.keep  = 8'hFF;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({s_axis.ready, pkt_valid, pkt_len, pkt_status} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: ready=%0b valid=%0b len=%0d status=%b required all 0",
               s_axis.ready, pkt_valid, pkt_len, pkt_status);
    end
    checks++;
    if ({pkt_cnt, bad_cnt, drop_cnt} !== '0) begin
      errors++;
      $display("FAIL midrst_counters: pkt=%0d bad=%0d drop=%0d required 0",
               pkt_cnt, bad_cnt, drop_cnt);
    end
    s_axis.valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    beat(8'h07, 1'b1, 1'b1, 1'b0);
    pop_check(16'd3, 4'b0000, "midrst_new");
    checks++;
    if (pkt_cnt !== 16'd1) begin
      errors++;
      $display("FAIL midrst_pkt_cnt: got %0d required 1", pkt_cnt);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    pkt_ready    = 1'b0;
    s_axis.valid = 1'b0;
    s_axis.data  = '0;
    s_axis.keep  = '0;
    s_axis.sop   = 1'b0;
    s_axis.eop   = 1'b0;
    s_axis.err   = 1'b0;
    test_reset();
    test_20byte();
    test_err_single();
    test_drop();
    test_flush();
    test_full();
    test_keep_err();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
